// File: rtl/execute_bru_bco_fifo.sv
// execute_bru_bco_fifo
// Buffers branch-commit/override updates from the BRU output stage, computes the
// updated 2-bit saturating branch pattern at enqueue, and drains the queue to the
// branch predictor under a valid/ready handshake. The BRU is never back-pressured:
// when the queue is full and nothing drains, the newest update is dropped and a
// sticky overflow flag is raised.

module execute_bru_bco_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_bco_valid,
    input  logic [31:0]      i_bco_pc,
    input  logic [1:0]       i_bco_oldpattern,
    input  logic             i_bco_taken,
    input  logic [31:0]      i_bco_target,
    output logic             o_bp_valid,
    input  logic             i_bp_ready,
    output logic [31:0]      o_bp_pc,
    output logic [1:0]       o_bp_newpattern,
    output logic             o_bp_taken,
    output logic [31:0]      o_bp_target,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_overflow
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] next_pattern(input logic [1:0] old_pat, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (old_pat == 2'd3) ? 2'd3 : (old_pat + 2'd1);
        end else begin
            res = (old_pat == 2'd0) ? 2'd0 : (old_pat - 2'd1);
        end
        return res;
    endfunction

    // Entry payload storage (deliberately not reset; head is don't-care while invalid).
    logic [31:0]     pc_mem_r     [DEPTH];
    logic [1:0]      pat_mem_r    [DEPTH];
    logic            taken_mem_r  [DEPTH];
    logic [31:0]     target_mem_r [DEPTH];

    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [PTR_W:0]   count_r;
    logic             valid_r;
    logic             full_r;
    logic             overflow_r;

    logic             enq_s;
    logic             deq_s;
    logic             drop_s;
    logic [1:0]       new_pat_s;
    logic [PTR_W:0]   count_nxt_s;

    // Handshake decode: a full queue still accepts when the head drains this cycle.
    always_comb begin
        deq_s       = valid_r & i_bp_ready;
        enq_s       = i_bco_valid & (~full_r | deq_s);
        drop_s      = i_bco_valid & ~enq_s;
        new_pat_s   = next_pattern(i_bco_oldpattern, i_bco_taken);
        count_nxt_s = count_r + {{PTR_W{1'b0}}, enq_s} - {{PTR_W{1'b0}}, deq_s};
    end

    // Payload write at the tail; no bypass, so a new entry is visible next cycle at the earliest.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            pc_mem_r[wptr_r]     <= i_bco_pc;
            pat_mem_r[wptr_r]    <= new_pat_s;
            taken_mem_r[wptr_r]  <= i_bco_taken;
            target_mem_r[wptr_r] <= i_bco_target;
        end else begin
            pc_mem_r[wptr_r]     <= pc_mem_r[wptr_r];
            pat_mem_r[wptr_r]    <= pat_mem_r[wptr_r];
            taken_mem_r[wptr_r]  <= taken_mem_r[wptr_r];
            target_mem_r[wptr_r] <= target_mem_r[wptr_r];
        end
    end

    // Pointer, occupancy and status state; valid/full are registered copies of the next count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_r     <= {PTR_W{1'b0}};
            rptr_r     <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W + 1){1'b0}};
            valid_r    <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (enq_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end else begin
                wptr_r <= wptr_r;
            end
            if (deq_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end else begin
                rptr_r <= rptr_r;
            end
            count_r    <= count_nxt_s;
            valid_r    <= (count_nxt_s != {(PTR_W + 1){1'b0}});
            full_r     <= (count_nxt_s == DEPTH_C);
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Head fields are read straight from the entry at the read pointer.
    always_comb begin
        o_bp_pc         = pc_mem_r[rptr_r];
        o_bp_newpattern = pat_mem_r[rptr_r];
        o_bp_taken      = taken_mem_r[rptr_r];
        o_bp_target     = target_mem_r[rptr_r];
    end

    assign o_bp_valid = valid_r;
    assign o_count    = count_r;
    assign o_full     = full_r;
    assign o_overflow = overflow_r;

endmodule

// File: tb/tb_execute_bru_bco_fifo.sv
// Testbench for execute_bru_bco_fifo: constant vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference model.

module tb_execute_bru_bco_fifo;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam logic [31:0] TGT_XOR = 32'hFFFF_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_bco_valid;
    logic [31:0]      i_bco_pc;
    logic [1:0]       i_bco_oldpattern;
    logic             i_bco_taken;
    logic [31:0]      i_bco_target;
    logic             o_bp_valid;
    logic             i_bp_ready;
    logic [31:0]      o_bp_pc;
    logic [1:0]       o_bp_newpattern;
    logic             o_bp_taken;
    logic [31:0]      o_bp_target;
    logic [PTR_W:0]   o_count;
    logic             o_full;
    logic             o_overflow;

    int errors = 0;
    int checks = 0;

    execute_bru_bco_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .i_bco_valid(i_bco_valid), .i_bco_pc(i_bco_pc),
        .i_bco_oldpattern(i_bco_oldpattern), .i_bco_taken(i_bco_taken),
        .i_bco_target(i_bco_target),
        .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready),
        .o_bp_pc(o_bp_pc), .o_bp_newpattern(o_bp_newpattern),
        .o_bp_taken(o_bp_taken), .o_bp_target(o_bp_target),
        .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [1:0]  pat;
        logic        taken;
        logic [31:0] tgt;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;

    function automatic logic [1:0] model_pattern(input logic [1:0] old_pat, input logic taken);
        int o;
        int n;
        o = int'(old_pat);
        if (taken) n = (o + 1 > 3) ? 3 : o + 1;
        else       n = (o - 1 < 0) ? 0 : o - 1;
        return 2'(n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(o_bp_valid), 32'(mq.size() != 0));
        chk("count", 32'(o_count), 32'(mq.size()));
        chk("full", 32'(o_full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk("head_pc", o_bp_pc, mq[0].pc);
            chk("head_pat", 32'(o_bp_newpattern), 32'(mq[0].pat));
            chk("head_taken", 32'(o_bp_taken), 32'(mq[0].taken));
            chk("head_target", o_bp_target, mq[0].tgt);
        end
    endtask

    // One clock with the given inputs; model advances from its pre-edge state.
    task automatic step(input logic v, input logic [31:0] pc, input logic [1:0] old_pat,
                        input logic tk, input logic rdy);
        bit   deq;
        bit   enq;
        ent_t e;
        i_bco_valid      = v;
        i_bco_pc         = pc;
        i_bco_oldpattern = old_pat;
        i_bco_taken      = tk;
        i_bco_target     = pc ^ TGT_XOR;
        i_bp_ready       = rdy;
        deq = (mq.size() != 0) && rdy;
        enq = v && ((mq.size() < DEPTH) || deq);
        @(posedge clk);
        #1;
        if (deq) void'(mq.pop_front());
        if (enq) begin
            e.pc = pc; e.pat = model_pattern(old_pat, tk); e.taken = tk; e.tgt = pc ^ TGT_XOR;
            mq.push_back(e);
        end
        if (v && !enq) m_ovf = 1'b1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_bco_valid = 1'b0;
        i_bp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // ---------------- constant vector table ----------------
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [1:0]  old_pat;
        logic        tk;
        logic        rdy;
        logic        ev;
        logic [2:0]  ec;
        logic        ef;
        logic        eo;
        logic [1:0]  ep;
        logic [31:0] epc;
        logic        etk;
    } vec_t;

    vec_t tv[14];

    initial begin
        // saturation: newpattern 3,0,2,1 each visible one cycle after enqueue
        tv[0]  = '{1'b1, 32'h10,  2'd3, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 2'd3, 32'h10,  1'b1};
        tv[1]  = '{1'b1, 32'h14,  2'd0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h14,  1'b0};
        tv[2]  = '{1'b1, 32'h18,  2'd1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 2'd2, 32'h18,  1'b1};
        tv[3]  = '{1'b1, 32'h1C,  2'd2, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 2'd1, 32'h1C,  1'b0};
        tv[4]  = '{1'b0, 32'h0,   2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 32'h0,   1'b0};
        // fill with predictor stalled; fifth update dropped
        tv[5]  = '{1'b1, 32'h100, 2'd1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 2'd2, 32'h100, 1'b1};
        tv[6]  = '{1'b1, 32'h104, 2'd1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 2'd2, 32'h100, 1'b1};
        tv[7]  = '{1'b1, 32'h108, 2'd1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 2'd2, 32'h100, 1'b1};
        tv[8]  = '{1'b1, 32'h10C, 2'd1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 2'd2, 32'h100, 1'b1};
        tv[9]  = '{1'b1, 32'h110, 2'd1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 2'd2, 32'h100, 1'b1};
        // drain in order
        tv[10] = '{1'b0, 32'h0,   2'd0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 2'd2, 32'h104, 1'b1};
        tv[11] = '{1'b0, 32'h0,   2'd0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 2'd2, 32'h108, 1'b1};
        tv[12] = '{1'b0, 32'h0,   2'd0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 2'd2, 32'h10C, 1'b1};
        tv[13] = '{1'b0, 32'h0,   2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 32'h0,   1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        reset            = 1'b1;
        i_bco_valid      = 1'b0;
        i_bco_pc         = 32'h0;
        i_bco_oldpattern = 2'd0;
        i_bco_taken      = 1'b0;
        i_bco_target     = 32'h0;
        i_bp_ready       = 1'b0;
        m_ovf            = 1'b0;

        // reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_bp_valid), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

        // table vectors
        for (int i = 0; i < 14; i++) begin
            i_bco_valid      = tv[i].v;
            i_bco_pc         = tv[i].pc;
            i_bco_oldpattern = tv[i].old_pat;
            i_bco_taken      = tv[i].tk;
            i_bco_target     = tv[i].pc ^ TGT_XOR;
            i_bp_ready       = tv[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d_valid", i), 32'(o_bp_valid), 32'(tv[i].ev));
            chk($sformatf("tv%0d_count", i), 32'(o_count), 32'(tv[i].ec));
            chk($sformatf("tv%0d_full", i), 32'(o_full), 32'(tv[i].ef));
            chk($sformatf("tv%0d_ovf", i), 32'(o_overflow), 32'(tv[i].eo));
            if (tv[i].ev) begin
                chk($sformatf("tv%0d_pc", i), o_bp_pc, tv[i].epc);
                chk($sformatf("tv%0d_pat", i), 32'(o_bp_newpattern), 32'(tv[i].ep));
                chk($sformatf("tv%0d_taken", i), 32'(o_bp_taken), 32'(tv[i].etk));
                chk($sformatf("tv%0d_target", i), o_bp_target, tv[i].epc ^ TGT_XOR);
            end
        end

        // full with simultaneous enqueue/dequeue: accepted, no overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 32'(4 * i), 2'(i), i[0], 1'b0);
        step(1'b1, 32'h200, 2'd2, 1'b1, 1'b1);
        chk("simul_count", 32'(o_count), 32'd4);
        chk("simul_ovf", 32'(o_overflow), 32'd0);
        chk("simul_head", o_bp_pc, 32'h104);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

        // empty with ready: nothing happens
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 32'h240, 2'd0, 1'b1, 1'b0);
        chk("after_empty_head", o_bp_pc, 32'h240);

        // randomized traffic with wrap-around against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0 || i < 20 ? $urandom_range(0, 1) : 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

        // reset mid-operation: discard immediately, restart from empty
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h280 + 32'(4 * i), 2'd1, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(o_bp_valid), 32'd0);
        chk("midrst_count", 32'(o_count), 32'd0);
        chk("midrst_full", 32'(o_full), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        step(1'b1, 32'h300, 2'd0, 1'b1, 1'b0);
        chk("midrst_new_head", o_bp_pc, 32'h300);
        chk("midrst_new_count", 32'(o_count), 32'd1);
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
